// File: rtl/forward_unit_multi_pkg.sv
// ============================================================================
//  Module   : pipeline_pkg
//  Purpose  : Shared widths, WB history entry type and hazard FSM states for
//             the operand bypass unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam int XLEN  = 32;
    localparam int RBITS = 5;

    typedef struct packed {
        logic             valid;
        logic [RBITS-1:0] rd;
        logic [XLEN-1:0]  data;
    } wb_entry_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } fwd_state_t;

endpackage

`default_nettype wire

// File: rtl/forward_unit_multi_if.sv
// ============================================================================
//  Module   : forward_unit_multi_if
//  Purpose  : WB, load and operand-port bundle between the pipeline and the
//             bypass/hazard unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface forward_unit_multi_if #(
    parameter int XLEN   = pipeline_pkg::XLEN,
    parameter int RBITS  = pipeline_pkg::RBITS,
    parameter int NPORTS = 2
);
    logic                    wb_valid;
    logic [RBITS-1:0]        wb_reg;
    logic [XLEN-1:0]         wb_data;
    logic                    ld_valid;
    logic [RBITS-1:0]        ld_reg;
    logic [NPORTS-1:0]       rs_used;
    logic [NPORTS*RBITS-1:0] rs_addr;
    logic [NPORTS*XLEN-1:0]  rs_data_in;
    logic [NPORTS*XLEN-1:0]  rs_data_out;
    logic [NPORTS-1:0]       fwd_hit;
    logic                    stall_req;

    modport master (
        output wb_valid, wb_reg, wb_data, ld_valid, ld_reg,
               rs_used, rs_addr, rs_data_in,
        input  rs_data_out, fwd_hit, stall_req
    );

    modport slave (
        input  wb_valid, wb_reg, wb_data, ld_valid, ld_reg,
               rs_used, rs_addr, rs_data_in,
        output rs_data_out, fwd_hit, stall_req
    );

endinterface

`default_nettype wire

// File: rtl/forward_unit_multi_fwd_history.sv
// ============================================================================
//  Module   : fwd_history
//  Purpose  : WB history shift chain; stage 0 is the live entry, stages
//             1..DEPTH-1 are registered copies that shift every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_history #(
    parameter int  DEPTH   = 2,
    parameter type ENTRY_T = pipeline_pkg::wb_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  ENTRY_T live,
    output ENTRY_T stage [DEPTH]
);

    assign stage[0] = live;

    // The chain never freezes: a stall still ages every entry by one stage.
    for (genvar k = 1; k < DEPTH; k++) begin : g_stage
        ENTRY_T r_entry;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_entry <= '0;
            end else begin
                r_entry <= stage[k-1];
            end
        end

        assign stage[k] = r_entry;
    end

endmodule

`default_nettype wire

// File: rtl/forward_unit_multi.sv
// ============================================================================
//  Module   : forward_unit_multi
//  Purpose  : Multi-port operand bypass from a WB history plus load-use
//             hazard detection holding stall_req for LD_LAT cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module forward_unit_multi #(
    parameter int XLEN   = pipeline_pkg::XLEN,
    parameter int RBITS  = pipeline_pkg::RBITS,
    parameter int NPORTS = 2,
    parameter int DEPTH  = 2,
    parameter int LD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    forward_unit_multi_if.slave  bus
);
    import pipeline_pkg::*;

    localparam int CNT_W = $clog2(LD_LAT + 1);

    typedef struct packed {
        logic             valid;
        logic [RBITS-1:0] rd;
        logic [XLEN-1:0]  data;
    } entry_t;

    entry_t w_live;
    entry_t w_stage [DEPTH];

    // Writes to r0 are stored invalid so they can never be forwarded.
    assign w_live.valid = bus.wb_valid & (bus.wb_reg != '0);
    assign w_live.rd    = bus.wb_reg;
    assign w_live.data  = bus.wb_data;

    fwd_history #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_history (
        .clk   (clk),
        .rst_n (rst_n),
        .live  (w_live),
        .stage (w_stage)
    );

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic [RBITS-1:0] w_addr;
        logic [XLEN-1:0]  w_data;
        logic             w_hit;

        assign w_addr = bus.rs_addr[p*RBITS +: RBITS];

        // Scan oldest to youngest so the youngest match is the last writer.
        always_comb begin
            w_data = bus.rs_data_in[p*XLEN +: XLEN];
            w_hit  = 1'b0;
            if (w_addr == '0) begin
                w_data = '0;
            end else begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (w_stage[k].valid && (w_stage[k].rd == w_addr)) begin
                        w_data = w_stage[k].data;
                        w_hit  = 1'b1;
                    end
                end
            end
        end

        assign bus.rs_data_out[p*XLEN +: XLEN] = w_data;
        assign bus.fwd_hit[p]                  = w_hit;
    end

    logic w_haz;

    always_comb begin
        w_haz = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            if (bus.rs_used[p] && (bus.rs_addr[p*RBITS +: RBITS] == bus.ld_reg)) begin
                w_haz = 1'b1;
            end
        end
        w_haz = w_haz & bus.ld_valid & (bus.ld_reg != '0);
    end

    fwd_state_t       r_state;
    fwd_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The IDLE cycle that sees the hazard is the first stall cycle; STALL
    // covers the remaining LD_LAT-1 cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall = w_haz;
                if (w_haz && (LD_LAT > 1)) begin
                    w_state_nxt = STALL;
                    w_cnt_nxt   = CNT_W'(LD_LAT - 1);
                end
            end
            STALL: begin
                w_stall = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.stall_req = w_stall;

endmodule

`default_nettype wire

// File: tb/tb_forward_unit_multi.sv
// ============================================================================
//  Module   : tb_forward_unit_multi
//  Purpose  : Directed and randomized checks of forward_unit_multi in three
//             parameterisations against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_forward_unit_multi;

    logic clk;
    logic rst_n;
    int   errs   = 0;
    int   checks = 0;

    forward_unit_multi_if #(.XLEN(32), .RBITS(5), .NPORTS(2)) ifa ();
    forward_unit_multi_if #(.XLEN(32), .RBITS(5), .NPORTS(3)) ifb ();
    forward_unit_multi_if #(.XLEN(32), .RBITS(5), .NPORTS(2)) ifc ();

    forward_unit_multi #(.XLEN(32), .RBITS(5), .NPORTS(2), .DEPTH(2), .LD_LAT(2))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    forward_unit_multi #(.XLEN(32), .RBITS(5), .NPORTS(3), .DEPTH(3), .LD_LAT(3))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    forward_unit_multi #(.XLEN(32), .RBITS(5), .NPORTS(2), .DEPTH(1), .LD_LAT(1))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          v;
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t hq [3][$];
    int   rem [3];
    int   dep [3] = '{2, 3, 1};
    int   ldl [3] = '{2, 3, 1};
    int   np  [3] = '{2, 3, 2};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ifa.wb_valid = 0; ifa.wb_reg = 0; ifa.wb_data = 0; ifa.ld_valid = 0; ifa.ld_reg = 0;
        ifa.rs_used = 0; ifa.rs_addr = 0; ifa.rs_data_in = 0;
        ifb.wb_valid = 0; ifb.wb_reg = 0; ifb.wb_data = 0; ifb.ld_valid = 0; ifb.ld_reg = 0;
        ifb.rs_used = 0; ifb.rs_addr = 0; ifb.rs_data_in = 0;
        ifc.wb_valid = 0; ifc.wb_reg = 0; ifc.wb_data = 0; ifc.ld_valid = 0; ifc.ld_reg = 0;
        ifc.rs_used = 0; ifc.rs_addr = 0; ifc.rs_data_in = 0;
    endtask

    task automatic pa(input int p, input logic [4:0] a, input logic u, input logic [31:0] d);
        ifa.rs_addr[p*5 +: 5] = a; ifa.rs_used[p] = u; ifa.rs_data_in[p*32 +: 32] = d;
    endtask
    task automatic pb(input int p, input logic [4:0] a, input logic u, input logic [31:0] d);
        ifb.rs_addr[p*5 +: 5] = a; ifb.rs_used[p] = u; ifb.rs_data_in[p*32 +: 32] = d;
    endtask
    task automatic pc(input int p, input logic [4:0] a, input logic u, input logic [31:0] d);
        ifc.rs_addr[p*5 +: 5] = a; ifc.rs_used[p] = u; ifc.rs_data_in[p*32 +: 32] = d;
    endtask

    function automatic logic [31:0] act_data(input int d, input int p);
        case (d)
            0:       return ifa.rs_data_out[p*32 +: 32];
            1:       return ifb.rs_data_out[p*32 +: 32];
            default: return ifc.rs_data_out[p*32 +: 32];
        endcase
    endfunction

    function automatic logic act_hit(input int d, input int p);
        case (d)
            0:       return ifa.fwd_hit[p];
            1:       return ifb.fwd_hit[p];
            default: return ifc.fwd_hit[p];
        endcase
    endfunction

    function automatic logic act_stall(input int d);
        case (d)
            0:       return ifa.stall_req;
            1:       return ifb.stall_req;
            default: return ifc.stall_req;
        endcase
    endfunction

    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        pa(0, 5'd5, 1'b1, 32'hAAAA);
        pa(1, 5'd0, 1'b1, 32'hBEEF);
        #2;
        checks++; if (ifa.rs_data_out[31:0] !== 32'hAAAA) begin errs++;
            $display("FAIL reset_data0 got=%h exp=%h", ifa.rs_data_out[31:0], 32'hAAAA); end
        checks++; if (ifa.rs_data_out[63:32] !== 32'h0) begin errs++;
            $display("FAIL reset_data_r0 got=%h exp=0", ifa.rs_data_out[63:32]); end
        checks++; if (ifa.fwd_hit !== 2'b00) begin errs++;
            $display("FAIL reset_hit got=%b exp=00", ifa.fwd_hit); end
        checks++; if ({ifa.stall_req, ifb.stall_req, ifc.stall_req} !== 3'b000) begin errs++;
            $display("FAIL reset_stall got=%b exp=000", {ifa.stall_req, ifb.stall_req, ifc.stall_req}); end
        step();
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_wb_bypass();
        idle_all();
        pa(0, 5'd5, 1'b1, 32'hAAAA);
        #2;
        checks++; if (ifa.rs_data_out[31:0] !== 32'hAAAA || ifa.fwd_hit[0] !== 1'b0 || ifa.stall_req !== 1'b0) begin
            errs++; $display("FAIL regfile_path got=%h/%b/%b exp=0000aaaa/0/0",
                ifa.rs_data_out[31:0], ifa.fwd_hit[0], ifa.stall_req); end
        step();
        ifa.wb_valid = 1; ifa.wb_reg = 5'd5; ifa.wb_data = 32'h11;
        #2;
        checks++; if (ifa.rs_data_out[31:0] !== 32'h11 || ifa.fwd_hit[0] !== 1'b1) begin errs++;
            $display("FAIL live_fwd got=%h/%b exp=00000011/1", ifa.rs_data_out[31:0], ifa.fwd_hit[0]); end
        step();
        ifa.wb_valid = 0; ifa.wb_data = 32'h0;
        #2;
        checks++; if (ifa.rs_data_out[31:0] !== 32'h11 || ifa.fwd_hit[0] !== 1'b1) begin errs++;
            $display("FAIL stage1_fwd got=%h/%b exp=00000011/1", ifa.rs_data_out[31:0], ifa.fwd_hit[0]); end
        step();
        #2;
        checks++; if (ifa.rs_data_out[31:0] !== 32'hAAAA || ifa.fwd_hit[0] !== 1'b0) begin errs++;
            $display("FAIL aged_out got=%h/%b exp=0000aaaa/0", ifa.rs_data_out[31:0], ifa.fwd_hit[0]); end
    endtask

    task automatic test_priority();
        step();
        idle_all();
        ifa.wb_valid = 1; ifa.wb_reg = 5'd7; ifa.wb_data = 32'h22;
        step();
        ifa.wb_data = 32'h33;
        pa(0, 5'd7, 1'b1, 32'h99);
        pa(1, 5'd7, 1'b1, 32'h98);
        #2;
        checks++; if (ifa.rs_data_out !== {32'h33, 32'h33} || ifa.fwd_hit !== 2'b11) begin errs++;
            $display("FAIL youngest_wins got=%h/%b exp=0000003300000033/11", ifa.rs_data_out, ifa.fwd_hit); end
        step();
        ifa.wb_reg = 5'd0; ifa.wb_data = 32'h44;
        pa(0, 5'd0, 1'b1, 32'h77);
        #2;
        checks++; if (ifa.rs_data_out[31:0] !== 32'h0 || ifa.fwd_hit[0] !== 1'b0) begin errs++;
            $display("FAIL r0_zero got=%h/%b exp=0/0", ifa.rs_data_out[31:0], ifa.fwd_hit[0]); end
        checks++; if (ifa.rs_data_out[63:32] !== 32'h33 || ifa.fwd_hit[1] !== 1'b1) begin errs++;
            $display("FAIL r7_stage1 got=%h/%b exp=00000033/1", ifa.rs_data_out[63:32], ifa.fwd_hit[1]); end
        step();
        ifa.wb_valid = 0;
        #2;
        checks++; if (ifa.rs_data_out[31:0] !== 32'h0 || ifa.fwd_hit !== 2'b00) begin errs++;
            $display("FAIL r0_not_stored got=%h/%b exp=0/00", ifa.rs_data_out[31:0], ifa.fwd_hit); end
    endtask

    task automatic test_load_use();
        idle_all();
        step();
        ifa.ld_valid = 1; ifa.ld_reg = 5'd9;
        pa(1, 5'd9, 1'b1, 32'h5);
        #2;
        checks++; if (ifa.stall_req !== 1'b1) begin errs++;
            $display("FAIL ld_stall_c0 got=%b exp=1", ifa.stall_req); end
        step();
        ifa.ld_valid = 0;
        #2;
        checks++; if (ifa.stall_req !== 1'b1) begin errs++;
            $display("FAIL ld_stall_c1 got=%b exp=1", ifa.stall_req); end
        step();
        #2;
        checks++; if (ifa.stall_req !== 1'b0) begin errs++;
            $display("FAIL ld_stall_end got=%b exp=0", ifa.stall_req); end
        // held hazard: two fresh LD_LAT=2 sequences back to back
        ifa.ld_valid = 1;
        for (int c = 0; c < 4; c++) begin
            #2;
            checks++; if (ifa.stall_req !== 1'b1) begin errs++;
                $display("FAIL ld_held_c%0d got=%b exp=1", c, ifa.stall_req); end
            step();
        end
        ifa.ld_valid = 0;
        #2;
        checks++; if (ifa.stall_req !== 1'b0) begin errs++;
            $display("FAIL ld_held_end got=%b exp=0", ifa.stall_req); end
        step();
        ifa.ld_valid = 1;
        pa(0, 5'd9, 1'b0, 32'h1);
        pa(1, 5'd9, 1'b0, 32'h2);
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if (ifa.stall_req !== 1'b0) begin errs++;
                $display("FAIL unused_port_c%0d got=%b exp=0", c, ifa.stall_req); end
            step();
        end
        ifa.ld_reg = 5'd0;
        pa(0, 5'd0, 1'b1, 32'h1);
        #2;
        checks++; if (ifa.stall_req !== 1'b0) begin errs++;
            $display("FAIL ld_r0 got=%b exp=0", ifa.stall_req); end
        idle_all();
        step();
    endtask

    task automatic test_reset_mid_stall();
        idle_all();
        ifb.wb_valid = 1; ifb.wb_reg = 5'd3; ifb.wb_data = 32'h55;
        ifb.ld_valid = 1; ifb.ld_reg = 5'd9;
        pb(0, 5'd9, 1'b1, 32'h10);
        pb(1, 5'd3, 1'b1, 32'h20);
        #2;
        checks++; if (ifb.stall_req !== 1'b1 || ifb.fwd_hit !== 3'b010) begin errs++;
            $display("FAIL ms_c0 got=%b/%b exp=1/010", ifb.stall_req, ifb.fwd_hit); end
        step();
        ifb.wb_valid = 0; ifb.ld_valid = 0;
        #2;
        checks++; if (ifb.stall_req !== 1'b1 || ifb.rs_data_out[63:32] !== 32'h55) begin errs++;
            $display("FAIL ms_c1 got=%b/%h exp=1/00000055", ifb.stall_req, ifb.rs_data_out[63:32]); end
        rst_n = 1'b0;
        #1;
        checks++; if (ifb.stall_req !== 1'b0 || ifb.fwd_hit !== 3'b000) begin errs++;
            $display("FAIL ms_async got=%b/%b exp=0/000", ifb.stall_req, ifb.fwd_hit); end
        checks++; if (ifb.rs_data_out[63:32] !== 32'h20) begin errs++;
            $display("FAIL ms_async_data got=%h exp=00000020", ifb.rs_data_out[63:32]); end
        step();
        rst_n = 1'b1;
        #2;
        checks++; if (ifb.stall_req !== 1'b0 || ifb.fwd_hit !== 3'b000) begin errs++;
            $display("FAIL ms_after got=%b/%b exp=0/000", ifb.stall_req, ifb.fwd_hit); end
        step();
        #2;
        checks++; if (ifb.stall_req !== 1'b0) begin errs++;
            $display("FAIL ms_idle got=%b exp=0", ifb.stall_req); end
    endtask

    task automatic test_depth1();
        idle_all();
        step();
        ifc.wb_valid = 1; ifc.wb_reg = 5'd4; ifc.wb_data = 32'h66;
        ifc.ld_valid = 1; ifc.ld_reg = 5'd4;
        pc(0, 5'd4, 1'b1, 32'h12);
        #2;
        checks++; if (ifc.rs_data_out[31:0] !== 32'h66 || ifc.fwd_hit[0] !== 1'b1 || ifc.stall_req !== 1'b1) begin
            errs++; $display("FAIL d1_c0 got=%h/%b/%b exp=00000066/1/1",
                ifc.rs_data_out[31:0], ifc.fwd_hit[0], ifc.stall_req); end
        step();
        ifc.wb_valid = 0;
        #2;
        checks++; if (ifc.rs_data_out[31:0] !== 32'h12 || ifc.fwd_hit[0] !== 1'b0 || ifc.stall_req !== 1'b1) begin
            errs++; $display("FAIL d1_c1 got=%h/%b/%b exp=00000012/0/1",
                ifc.rs_data_out[31:0], ifc.fwd_hit[0], ifc.stall_req); end
        step();
        ifc.ld_valid = 0;
        #2;
        checks++; if (ifc.stall_req !== 1'b0) begin errs++;
            $display("FAIL d1_c2 got=%b exp=0", ifc.stall_req); end
    endtask

    task automatic test_random();
        logic [4:0]  ra [3];
        logic        ru [3];
        logic [31:0] rdi [3];
        logic        wv, lv;
        logic [4:0]  wr, lr;
        logic [31:0] wd;
        ent_t        live;
        ent_t        cand [$];
        logic [31:0] exp_d;
        logic        exp_h;
        logic        haz;

        idle_all();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            hq[d].delete();
            rem[d] = 0;
        end
        for (int n = 0; n < 400; n++) begin
            wv = ($urandom_range(0, 3) != 0);
            wr = 5'($urandom_range(0, 7));
            wd = $urandom;
            lv = ($urandom_range(0, 3) == 0);
            lr = 5'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++) begin
                ra[p]  = 5'($urandom_range(0, 7));
                ru[p]  = ($urandom_range(0, 1) == 1);
                rdi[p] = $urandom;
            end
            ifa.wb_valid = wv; ifa.wb_reg = wr; ifa.wb_data = wd; ifa.ld_valid = lv; ifa.ld_reg = lr;
            ifb.wb_valid = wv; ifb.wb_reg = wr; ifb.wb_data = wd; ifb.ld_valid = lv; ifb.ld_reg = lr;
            ifc.wb_valid = wv; ifc.wb_reg = wr; ifc.wb_data = wd; ifc.ld_valid = lv; ifc.ld_reg = lr;
            for (int p = 0; p < 2; p++) begin
                pa(p, ra[p], ru[p], rdi[p]);
                pc(p, ra[p], ru[p], rdi[p]);
            end
            for (int p = 0; p < 3; p++) pb(p, ra[p], ru[p], rdi[p]);
            #2;
            live.v = wv && (wr != 5'd0);
            live.r = wr;
            live.d = wd;
            for (int d = 0; d < 3; d++) begin
                cand = {live, hq[d]};
                for (int p = 0; p < np[d]; p++) begin
                    exp_d = rdi[p];
                    exp_h = 1'b0;
                    if (ra[p] == 5'd0) begin
                        exp_d = 32'h0;
                    end else begin
                        foreach (cand[i]) begin
                            if (!exp_h && cand[i].v && cand[i].r == ra[p]) begin
                                exp_d = cand[i].d;
                                exp_h = 1'b1;
                            end
                        end
                    end
                    checks++;
                    if (act_data(d, p) !== exp_d || act_hit(d, p) !== exp_h) begin
                        errs++;
                        $display("FAIL rand_port dut%0d p%0d cyc%0d got=%h/%b exp=%h/%b",
                            d, p, n, act_data(d, p), act_hit(d, p), exp_d, exp_h);
                    end
                end
                haz = 1'b0;
                for (int p = 0; p < np[d]; p++)
                    if (ru[p] && ra[p] == lr) haz = 1'b1;
                haz = haz && lv && (lr != 5'd0);
                if (rem[d] == 0 && haz) rem[d] = ldl[d];
                checks++;
                if (act_stall(d) !== (rem[d] > 0)) begin
                    errs++;
                    $display("FAIL rand_stall dut%0d cyc%0d got=%b exp=%b", d, n, act_stall(d), rem[d] > 0);
                end
            end
            @(posedge clk);
            for (int d = 0; d < 3; d++) begin
                hq[d].push_front(live);
                while (hq[d].size() > dep[d] - 1) void'(hq[d].pop_back());
                if (rem[d] > 0) rem[d]--;
            end
            #1;
        end
        idle_all();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        #1;
        test_reset();
        test_wb_bypass();
        test_priority();
        test_load_use();
        test_reset_mid_stall();
        test_depth1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
